// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous-read RAM port between instruction fetch and the
// memory stage, routing read data back to whichever requester issued it.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_stall,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_gnt,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wstrb,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_MEM  = 2'd2
    } resp_e;

    resp_e            r_state;
    resp_e            w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_override;
    logic             w_if_gnt;
    logic             w_mem_gnt;

    // Grant decision; gated by reset_n so nothing issues while reset is held.
    always_comb begin
        w_override = (STARVE_LIMIT != 0) && (r_starve_cnt == LIMIT_C);
        w_mem_gnt  = reset_n & mem_req & ~(if_req & w_override);
        w_if_gnt   = reset_n & if_req & ~w_mem_gnt;
        mem_gnt    = w_mem_gnt;
        if_gnt     = w_if_gnt;
        if_stall   = if_req & ~w_if_gnt;
    end

    // RAM port mux for the winning requester.
    always_comb begin
        ram_addr  = {ADDR_W{1'b0}};
        ram_we    = 1'b0;
        ram_wdata = {DATA_W{1'b0}};
        ram_wstrb = {STRB_W{1'b0}};
        if (w_mem_gnt) begin
            ram_addr  = mem_addr;
            ram_we    = mem_we;
            ram_wdata = mem_wdata;
            ram_wstrb = mem_we ? mem_wstrb : {STRB_W{1'b0}};
        end else if (w_if_gnt) begin
            ram_addr  = if_addr;
        end else begin
            ram_addr  = {ADDR_W{1'b0}};
        end
    end

    // Saturating count of consecutive cycles fetch asked and was refused.
    always_comb begin
        w_starve_nxt = {CNT_W{1'b0}};
        if (if_req & ~w_if_gnt) begin
            if (r_starve_cnt == LIMIT_C) begin
                w_starve_nxt = r_starve_cnt;
            end else begin
                w_starve_nxt = r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            w_starve_nxt = {CNT_W{1'b0}};
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Response state register: remembers who owns the data arriving this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= R_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response routing and next state; stores never produce a response.
    always_comb begin
        if_rvalid  = 1'b0;
        if_rdata   = {DATA_W{1'b0}};
        mem_rvalid = 1'b0;
        mem_rdata  = {DATA_W{1'b0}};
        case (r_state)
            R_IF: begin
                if_rvalid  = 1'b1;
                if_rdata   = ram_rdata;
            end
            R_MEM: begin
                mem_rvalid = 1'b1;
                mem_rdata  = ram_rdata;
            end
            R_NONE: begin
                if_rvalid  = 1'b0;
            end
            default: begin
                if_rvalid  = 1'b0;
            end
        endcase
        if (w_if_gnt) begin
            w_state_nxt = R_IF;
        end else if (w_mem_gnt & ~mem_we) begin
            w_state_nxt = R_MEM;
        end else begin
            w_state_nxt = R_NONE;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a behavioural
// model of the arbitration rules; the RAM model returns {~addr, addr}.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LIMIT  = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = 16'h0;
    logic              if_gnt, if_stall, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] mem_addr = 16'h0;
    logic [DATA_W-1:0] mem_wdata = 32'h0;
    logic [STRB_W-1:0] mem_wstrb = 4'h0;
    logic              mem_gnt, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [STRB_W-1:0] ram_wstrb;
    logic [DATA_W-1:0] ram_rdata = 32'h0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= {~ram_addr, ram_addr};

    int tests = 0;
    int fails = 0;

    // Reference model: how many cycles fetch has been refused in a row, and
    // which read (if any) was issued last cycle.
    int                streak = 0;
    int                pend_kind = 0;
    logic [ADDR_W-1:0] pend_addr = 16'h0;
    logic              e_if = 1'b0;
    logic              e_mem = 1'b0;
    logic              last_if_gnt = 1'b0;
    logic              last_mem_gnt = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        streak    = 0;
        pend_kind = 0;
        e_if      = 1'b0;
        e_mem     = 1'b0;
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_if_gnt"},     if_gnt,     64'h0);
        chk({tag, "_mem_gnt"},    mem_gnt,    64'h0);
        chk({tag, "_if_rvalid"},  if_rvalid,  64'h0);
        chk({tag, "_mem_rvalid"}, mem_rvalid, 64'h0);
        chk({tag, "_ram_we"},     ram_we,     64'h0);
        chk({tag, "_ram_addr"},   ram_addr,   64'h0);
        chk({tag, "_ram_wdata"},  ram_wdata,  64'h0);
        chk({tag, "_ram_wstrb"},  ram_wstrb,  64'h0);
        chk({tag, "_if_rdata"},   if_rdata,   64'h0);
        chk({tag, "_mem_rdata"},  mem_rdata,  64'h0);
    endtask

    task automatic drive_check(input bit wait_edge, input logic ir, input logic [ADDR_W-1:0] ia,
                               input logic mr, input logic mw, input logic [ADDR_W-1:0] ma,
                               input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] ws);
        logic              owed;
        logic [DATA_W-1:0] exp_rd;
        if (wait_edge) @(negedge clk);
        if_req = ir; if_addr = ia;
        mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = wd; mem_wstrb = ws;
        #1;
        owed  = (LIMIT != 0) && (streak == LIMIT);
        e_mem = mr && !(ir && owed);
        e_if  = ir && !e_mem;
        chk("if_gnt",   if_gnt,   {63'h0, e_if});
        chk("mem_gnt",  mem_gnt,  {63'h0, e_mem});
        chk("if_stall", if_stall, {63'h0, ir && !e_if});
        if (e_mem) begin
            chk("ram_addr_mem",  ram_addr,  {48'h0, ma});
            chk("ram_we_mem",    ram_we,    {63'h0, mw});
            chk("ram_wdata_mem", ram_wdata, {32'h0, wd});
            chk("ram_wstrb_mem", ram_wstrb, mw ? {60'h0, ws} : 64'h0);
        end else if (e_if) begin
            chk("ram_addr_if",  ram_addr,  {48'h0, ia});
            chk("ram_we_if",    ram_we,    64'h0);
            chk("ram_wstrb_if", ram_wstrb, 64'h0);
        end else begin
            chk("ram_addr_idle",  ram_addr,  64'h0);
            chk("ram_we_idle",    ram_we,    64'h0);
            chk("ram_wdata_idle", ram_wdata, 64'h0);
            chk("ram_wstrb_idle", ram_wstrb, 64'h0);
        end
        exp_rd = {~pend_addr, pend_addr};
        chk("if_rvalid",  if_rvalid,  (pend_kind == 1) ? 64'h1 : 64'h0);
        chk("if_rdata",   if_rdata,   (pend_kind == 1) ? {32'h0, exp_rd} : 64'h0);
        chk("mem_rvalid", mem_rvalid, (pend_kind == 2) ? 64'h1 : 64'h0);
        chk("mem_rdata",  mem_rdata,  (pend_kind == 2) ? {32'h0, exp_rd} : 64'h0);
        last_if_gnt  = if_gnt;
        last_mem_gnt = mem_gnt;
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_if) begin
            pend_kind = 1; pend_addr = if_addr;
        end else if (e_mem && !mem_we) begin
            pend_kind = 2; pend_addr = mem_addr;
        end else begin
            pend_kind = 0;
        end
        if (if_req && !e_if) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
        else streak = 0;
    endtask

    task automatic step(input logic ir, input logic [ADDR_W-1:0] ia, input logic mr, input logic mw,
                        input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] ws);
        drive_check(1'b1, ir, ia, mr, mw, ma, wd, ws);
        advance();
    endtask

    initial begin
        logic [4:0]        pat_if;
        logic [4:0]        pat_mem;
        logic              ir, mr, mw;
        logic [ADDR_W-1:0] ia, ma;
        logic [DATA_W-1:0] wd;
        logic [STRB_W-1:0] ws;

        // Reset held with a fetch pending: everything quiet.
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk); #1;
        check_reset_zero("rst");
        @(negedge clk); #1;
        check_reset_zero("rst2");
        #1 reset_n = 1'b1;
        model_reset();
        drive_check(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        advance();
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        // Contention: memory load wins, fetch retries next cycle.
        step(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0200, 32'h0, 4'h0);
        step(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        // Store: one write cycle, no response.
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0300, 32'hDEADBEEF, 4'h3);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        // Starvation: fetch is refused three times then overrides memory.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i < 4) ? 16'h0080 : 16'h0084, 1'b1, 1'b0,
                 (i < 4) ? 16'(16'h0400 + 4 * i) : 16'h040C, 32'h0, 4'h0);
            pat_if[i]  = last_if_gnt;
            pat_mem[i] = last_mem_gnt;
        end
        chk("starve_if_pattern",  pat_if,  64'h08);
        chk("starve_mem_pattern", pat_mem, 64'h17);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        // Interleave fetches and loads every cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            else            step(1'b0, 16'h0, 1'b1, 1'b0, 16'(16'h2000 + i), 32'h0, 4'h0);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        // Build up starvation, issue a load, then reset before it returns.
        step(1'b1, 16'h0090, 1'b1, 1'b0, 16'h0500, 32'h0, 4'h0);
        step(1'b1, 16'h0090, 1'b1, 1'b0, 16'h0504, 32'h0, 4'h0);
        drive_check(1'b1, 1'b1, 16'h0090, 1'b1, 1'b0, 16'h0508, 32'h0, 4'h0);
        #1 reset_n = 1'b0;
        #1 check_reset_zero("midrst");
        @(posedge clk);
        @(negedge clk); #1;
        check_reset_zero("midrst2");
        #1 reset_n = 1'b1;
        model_reset();
        drive_check(1'b0, 1'b1, 16'h0090, 1'b1, 1'b0, 16'h0600, 32'h0, 4'h0);
        advance();
        for (int i = 1; i < 5; i++) step(1'b1, 16'h0090, 1'b1, 1'b0, 16'(16'h0600 + 4 * i), 32'h0, 4'h0);

        // Random traffic; an ungranted requester keeps its request stable.
        ir = 1'b0; mr = 1'b0; mw = 1'b0; ia = 16'h0; ma = 16'h0; wd = 32'h0; ws = 4'h0;
        e_if = 1'b0; e_mem = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!(ir && !e_if)) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = 16'($urandom);
            end
            if (!(mr && !e_mem)) begin
                mr = ($urandom_range(0, 2) != 0);
                mw = 1'($urandom);
                ma = 16'($urandom);
                wd = $urandom;
                ws = 4'($urandom);
            end
            step(ir, ia, mr, mw, ma, wd, ws);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
